mux_rr_arb: RTL and testbench

- Parametrised N-way, WIDTH-bit multiplexer with valid/ready channels and a one-entry registered output.
- Selection runs in one of two modes: fixed, where external select S picks the channel, or round-robin, where an internal fair arbiter picks it.
- Sits between multiple datapath producers (register-file read ports, immediate, ALU result, memory data) and a single consumer such as the register-file write port or bus.
- Replaces the fixed-width combinational 8:1 select.

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/mux_rr_arb.sv | 80 ++++++++
 tb/tb_mux_rr_arb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and default sizing for the valid/ready channel multiplexer.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_N     = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int N    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] idx
);

  logic found;
  int   cand;

  // NOTE: every variable written here gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = SELW'(cand);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// N-way valid/ready multiplexer with fixed or round-robin selection and a one-entry output register.
module mux_rr_arb
  import mux_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int N     = DEFAULT_N,
  localparam int SELW  = $clog2(N)
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               Mode,
  input  logic [SELW-1:0]    S,
  input  logic [N-1:0]       In_Valid,
  output logic [N-1:0]       In_Ready,
  input  logic [N*WIDTH-1:0] In_Data,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [WIDTH-1:0]   Out_Data,
  output logic [SELW-1:0]    Out_Sel
);

  mux_mode_t        mode;
  logic             load;
  logic [SELW-1:0]  ptr;
  logic [N-1:0]     rr_gnt;
  logic [SELW-1:0]  rr_idx;
  logic [N-1:0]     fix_gnt;
  logic [N-1:0]     gnt;
  logic [SELW-1:0]  sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             xfer;

  assign mode = mux_mode_t'(Mode);

  // Register can accept when empty or being drained this cycle; nothing is accepted under reset.
  assign load = ResetN & (!Out_Valid | Out_Ready);

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req (In_Valid),
    .ptr (ptr),
    .en  (load && (mode == MODE_RR)),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  // An out-of-range S (non-power-of-2 N) yields no grant.
  always_comb begin
    fix_gnt = '0;
    if (load && (mode == MODE_FIXED) && (int'(S) < N) && In_Valid[S])
      fix_gnt[S] = 1'b1;
  end

  assign gnt      = (mode == MODE_RR) ? rr_gnt : fix_gnt;
  assign sel_idx  = (mode == MODE_RR) ? rr_idx : S;
  assign sel_data = In_Data[sel_idx*WIDTH +: WIDTH];
  assign xfer     = |gnt;
  assign In_Ready = gnt;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
      Out_Sel   <= '0;
      ptr       <= SELW'(N - 1);
    end else begin
      if (xfer) begin
        Out_Valid <= 1'b1;
        Out_Data  <= sel_data;
        Out_Sel   <= sel_idx;
      end else if (Out_Ready) begin
        Out_Valid <= 1'b0;
      end
      // Pointer only advances on round-robin transfers, so it survives fixed-mode intervals.
      if (xfer && (mode == MODE_RR))
        ptr <= rr_idx;
    end
  end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed self-checking bench for mux_rr_arb with hand-computed grants and outputs.
module tb_mux_rr_arb;

  localparam int WIDTH = 16;
  localparam int N     = 8;
  localparam int SELW  = 3;

  logic               Clk;
  logic               ResetN;
  logic               Mode;
  logic [SELW-1:0]    S;
  logic [N-1:0]       In_Valid;
  logic [N-1:0]       In_Ready;
  logic [N*WIDTH-1:0] In_Data;
  logic               Out_Valid;
  logic               Out_Ready;
  logic [WIDTH-1:0]   Out_Data;
  logic [SELW-1:0]    Out_Sel;

  logic [WIDTH-1:0] ch_data [N];

  int checks = 0;
  int errors = 0;
  int gcount [N];

  mux_rr_arb #(.WIDTH(WIDTH), .N(N)) dut (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .Mode      (Mode),
    .S         (S),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Data   (In_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Out_Sel   (Out_Sel)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always_comb begin
    In_Data = '0;
    for (int i = 0; i < N; i++) In_Data[i*WIDTH +: WIDTH] = ch_data[i];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Check a registered output triple after the edge.
  task automatic check_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                           input logic [SELW-1:0] s);
    check({tag, "_valid"}, 32'(Out_Valid), 32'(v));
    check({tag, "_data"},  32'(Out_Data),  32'(d));
    check({tag, "_sel"},   32'(Out_Sel),   32'(s));
  endtask

  initial begin
    int ch;
    for (int i = 0; i < N; i++) begin
      ch_data[i] = 16'h1000 + 16'(i);
      gcount[i]  = 0;
    end
    ResetN    = 1'b0;
    Mode      = 1'b1;
    S         = '0;
    In_Valid  = 8'hFF;
    Out_Ready = 1'b1;

    // Reset state
    #3;
    check_out("reset", 1'b0, 16'h0000, 3'd0);
    check("reset_ready", 32'(In_Ready), 32'h00);
    tick();
    check("reset_ready_edge", 32'(In_Ready), 32'h00);
    ResetN = 1'b1;
    #1;

    // Round-robin, all valid: 0..7 twice
    for (int k = 0; k < 16; k++) begin
      ch = k % N;
      check($sformatf("rr_ready_%0d", k), 32'(In_Ready), 32'(8'h01 << ch));
      for (int i = 0; i < N; i++) if (In_Ready[i]) gcount[i]++;
      tick();
      check_out($sformatf("rr_out_%0d", k), 1'b1, 16'h1000 + 16'(ch), SELW'(ch));
    end
    for (int i = 0; i < N; i++) check($sformatf("rr_count_%0d", i), 32'(gcount[i]), 32'd2);

    // Fixed mode sweep of S
    Mode = 1'b0;
    for (int s = 0; s < N; s++) begin
      S = SELW'(s);
      #1;
      check($sformatf("fix_ready_%0d", s), 32'(In_Ready), 32'(8'h01 << s));
      tick();
      check_out($sformatf("fix_out_%0d", s), 1'b1, 16'h1000 + 16'(s), SELW'(s));
    end

    // Single requester channel 5 (pointer still 7 from the RR run)
    Mode = 1'b1;
    In_Valid = 8'h20;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("single5_ready_%0d", k), 32'(In_Ready), 32'h20);
      tick();
      check($sformatf("single5_sel_%0d", k), 32'(Out_Sel), 32'd5);
    end

    // Sparse: channels 2 and 5 alternate starting from pointer 5
    In_Valid = 8'h24;
    for (int k = 0; k < 4; k++) begin
      ch = (k % 2 == 0) ? 2 : 5;
      #1;
      check($sformatf("sparse_ready_%0d", k), 32'(In_Ready), 32'(8'h01 << ch));
      tick();
      check_out($sformatf("sparse_out_%0d", k), 1'b1, 16'h1000 + 16'(ch), SELW'(ch));
    end

    // Load BEEF via fixed S=6, then stall for 3 cycles
    Mode = 1'b0;
    S = 3'd6;
    ch_data[6] = 16'hBEEF;
    In_Valid = 8'h40;
    tick();
    check_out("beef_load", 1'b1, 16'hBEEF, 3'd6);
    Mode = 1'b1;
    Out_Ready = 1'b0;
    ch_data[3] = 16'h0033;
    In_Valid = 8'h08;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall_ready_%0d", k), 32'(In_Ready), 32'h00);
      tick();
      check_out($sformatf("stall_out_%0d", k), 1'b1, 16'hBEEF, 3'd6);
    end
    Out_Ready = 1'b1;
    #1;
    check("unstall_ready", 32'(In_Ready), 32'h08);
    tick();
    check_out("unstall_out", 1'b1, 16'h0033, 3'd3);

    // Drain with no requesters: valid drops, data and sel hold
    In_Valid = 8'h00;
    #1;
    check("drain_ready", 32'(In_Ready), 32'h00);
    tick();
    check_out("drain_out", 1'b0, 16'h0033, 3'd3);

    // Mode switch: RR grant 4, fixed S=1 twice, back to RR expects 5
    In_Valid = 8'h10;
    #1;
    check("ms_rr4_ready", 32'(In_Ready), 32'h10);
    tick();
    check_out("ms_rr4_out", 1'b1, 16'h1004, 3'd4);
    Mode = 1'b0;
    S = 3'd1;
    In_Valid = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("ms_fix_ready_%0d", k), 32'(In_Ready), 32'h02);
      tick();
      check_out($sformatf("ms_fix_out_%0d", k), 1'b1, 16'h1001, 3'd1);
    end
    Mode = 1'b1;
    #1;
    check("ms_rr5_ready", 32'(In_Ready), 32'h20);
    tick();
    check_out("ms_rr5_out", 1'b1, 16'h1005, 3'd5);

    // Asynchronous reset mid-stream, then first grant goes to channel 0
    #2;
    ResetN = 1'b0;
    #1;
    check_out("midreset", 1'b0, 16'h0000, 3'd0);
    check("midreset_ready", 32'(In_Ready), 32'h00);
    tick();
    #2;
    ResetN = 1'b1;
    #1;
    check("postreset_ready", 32'(In_Ready), 32'h01);
    tick();
    check_out("postreset_out", 1'b1, 16'h1000, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
